fetch_stage: RTL and testbench

Instruction-fetch stage of the RISC-V core. It owns the program counter and drives the byte address into the instruction memory. It captures the returned instruction into an IF/ID pipeline register, which feeds decode through a valid/ready handshake. Branch and jump redirects from later stages flush the IF/ID register and reload the PC. A misaligned redirect target raises a sticky fault.

---
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures imem_rdata into the IF/ID register
// toward decode, and takes redirects from later stages. A misaligned redirect locks into a sticky fault.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc_plus4;
  logic        r_fault;
  logic [31:0] r_fault_pc;
  logic        w_capture;
  logic        w_redirect_ok;
  logic        w_redirect_bad;
  logic [31:0] w_pc_plus4;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; an aligned redirect in IDLE keeps us in IDLE so a start vector can be set first
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_redirect_bad)                   w_next_state = S_FAULT;
        else if (!redirect_valid && fetch_en) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (w_redirect_bad) w_next_state = S_FAULT;
      end
      default: w_next_state = S_FAULT;
    endcase
  end

  // Handshake: an IF/ID transfer happens on any rising edge where id_valid && id_ready;
  // once id_valid is raised, the contents stay bit-stable until that edge or a flush.
  always_comb begin
    w_redirect_ok  = 1'b0;
    w_redirect_bad = 1'b0;
    w_capture      = 1'b0;
    w_pc_plus4     = r_pc + 32'd4;
    if (r_state != S_FAULT && redirect_valid) begin
      w_redirect_ok  = (redirect_pc[1:0] == 2'b00);
      w_redirect_bad = (redirect_pc[1:0] != 2'b00);
    end
    w_capture = (r_state == S_RUN) && fetch_en && !redirect_valid && (!r_id_valid || id_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_id_valid    <= 1'b0;
      r_id_instr    <= 32'd0;
      r_id_pc       <= 32'd0;
      r_id_pc_plus4 <= 32'd0;
      r_fault       <= 1'b0;
      r_fault_pc    <= 32'd0;
    end else if (w_redirect_ok) begin
      r_pc       <= redirect_pc;
      r_id_valid <= 1'b0;
    end else if (w_redirect_bad) begin
      r_fault    <= 1'b1;
      r_fault_pc <= redirect_pc;
      r_id_valid <= 1'b0;
    end else if (w_capture) begin
      r_id_instr    <= imem_rdata;
      r_id_pc       <= r_pc;
      r_id_pc_plus4 <= w_pc_plus4;
      r_id_valid    <= 1'b1;
      r_pc          <= w_pc_plus4;
    end else if (r_id_valid && id_ready) begin
      r_id_valid <= 1'b0;
    end
  end

  assign imem_addr   = r_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign fault       = r_fault;
  assign fault_pc    = r_fault_pc;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a combinational memory model, scenario tasks with inline checks,
// and a scoreboard of expected {pc, instr} transfers drained on each IF/ID handshake.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic [1:0]  dbg_state;

  logic        reset2;
  logic        fetch_en2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic        id_valid2;
  logic [31:0] id_instr2;
  logic [31:0] id_pc2;
  logic [31:0] id_pc_plus42;
  logic        fault2;
  logic [31:0] fault_pc2;
  logic [1:0]  dbg_state2;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0000_0000;
      32'h0000_0004: mem_word = 32'h0198_06B3;
      32'h0000_0008: mem_word = 32'h4034_02B3;
      32'h0000_002C: mem_word = 32'h0094_8663;
      default:       mem_word = a ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_rdata  = mem_word(imem_addr);
  assign imem_rdata2 = mem_word(imem_addr2);

  fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fault(fault), .fault_pc(fault_pc), .o_dbg_state(dbg_state)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset2), .fetch_en(fetch_en2),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .id_valid(id_valid2), .id_ready(1'b1), .id_instr(id_instr2),
    .id_pc(id_pc2), .id_pc_plus4(id_pc_plus42),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .fault(fault2), .fault_pc(fault_pc2), .o_dbg_state(dbg_state2)
  );

  // Inputs change 2 time units after posedge, so negedge sees what the next posedge will use
  always @(negedge clk) begin
    if (!reset && id_valid && id_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: transfer id_pc=%h id_instr=%h, expected none", id_pc, id_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (id_pc !== e[63:32] || id_instr !== e[31:0] || id_pc_plus4 !== e[63:32] + 32'd4) begin
          errors++;
          $display("FAIL sb_transfer: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                   id_pc, id_instr, id_pc_plus4, e[63:32], e[31:0], e[63:32] + 32'd4);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic test_reset();
    reset = 1'b1; reset2 = 1'b1; fetch_en = 1'b0; fetch_en2 = 1'b0;
    id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
    checks++;
    if (imem_addr !== 32'h0 || id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0 ||
        id_pc_plus4 !== 32'h0 || fault !== 1'b0 || fault_pc !== 32'h0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: addr=%h v=%b instr=%h pc=%h pc4=%h f=%b fpc=%h st=%0d, expected all 0",
               imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fault, fault_pc, dbg_state);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_streaming();
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    fetch_en = 1'b1; id_ready = 1'b1;
    tick();
    checks++;
    if (id_valid !== 1'b0 || dbg_state !== ST_RUN || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL stream_start: v=%b st=%0d addr=%h, expected v=0 st=1 addr=0", id_valid, dbg_state, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(i * 4) || id_instr !== mem_word(32'(i * 4)) ||
          id_pc_plus4 !== 32'(i * 4 + 4) || imem_addr !== 32'(i * 4 + 4)) begin
        errors++;
        $display("FAIL stream_%0d: v=%b pc=%h instr=%h pc4=%h addr=%h, expected pc=%h instr=%h",
                 i, id_valid, id_pc, id_instr, id_pc_plus4, imem_addr, 32'(i * 4), mem_word(32'(i * 4)));
      end
    end
    id_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'h4034_02B3 || imem_addr !== 32'hC) begin
        errors++;
        $display("FAIL stall_hold_%0d: v=%b pc=%h instr=%h addr=%h, expected v=1 pc=8 instr=403402b3 addr=c",
                 i, id_valid, id_pc, id_instr, imem_addr);
      end
    end
    push_exp(32'hC);
    id_ready = 1'b1;
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'hC) begin
      errors++;
      $display("FAIL stall_release_12: v=%b pc=%h, expected v=1 pc=c", id_valid, id_pc);
    end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h10) begin
      errors++;
      $display("FAIL stall_release_16: v=%b pc=%h, expected v=1 pc=10", id_valid, id_pc);
    end
    id_ready = 1'b0;
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'd44;
    tick();
    checks++;
    if (id_valid !== 1'b0 || imem_addr !== 32'd44) begin
      errors++;
      $display("FAIL redirect_flush: v=%b addr=%h, expected v=0 addr=2c", id_valid, imem_addr);
    end
    redirect_valid = 1'b0; id_ready = 1'b1;
    push_exp(32'd44);
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'd44 || id_instr !== 32'h0094_8663 || id_pc_plus4 !== 32'd48) begin
      errors++;
      $display("FAIL redirect_target: v=%b pc=%h instr=%h pc4=%h, expected v=1 pc=2c instr=00948663 pc4=30",
               id_valid, id_pc, id_instr, id_pc_plus4);
    end
    fetch_en = 1'b0;
    tick();
    checks++;
    if (id_valid !== 1'b0 || imem_addr !== 32'd48) begin
      errors++;
      $display("FAIL pause_drain: v=%b addr=%h, expected v=0 addr=30", id_valid, imem_addr);
    end
  endtask

  task automatic test_async_reset();
    fetch_en = 1'b1; id_ready = 1'b0;
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'd48 || fault !== 1'b0) begin
      errors++;
      $display("FAIL areset_pre: v=%b pc=%h f=%b, expected v=1 pc=30 f=0", id_valid, id_pc, fault);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0 ||
        imem_addr !== 32'h0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL areset_immediate: v=%b instr=%h pc=%h pc4=%h addr=%h st=%0d, expected all 0",
               id_valid, id_instr, id_pc, id_pc_plus4, imem_addr, dbg_state);
    end
    fetch_en = 1'b0;
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (id_valid !== 1'b0 || dbg_state !== ST_IDLE || imem_addr !== 32'h0) begin
        errors++;
        $display("FAIL areset_idle_%0d: v=%b st=%0d addr=%h, expected v=0 st=0 addr=0", i, id_valid, dbg_state, imem_addr);
      end
    end
  endtask

  task automatic test_idle_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h100; fetch_en = 1'b1; id_ready = 1'b1;
    tick();
    checks++;
    if (dbg_state !== ST_IDLE || imem_addr !== 32'h100 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_redirect: st=%0d addr=%h v=%b, expected st=0 addr=100 v=0", dbg_state, imem_addr, id_valid);
    end
    redirect_valid = 1'b0;
    push_exp(32'h100);
    tick();
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== mem_word(32'h100)) begin
      errors++;
      $display("FAIL idle_start_vec: v=%b pc=%h instr=%h, expected v=1 pc=100 instr=%h",
               id_valid, id_pc, id_instr, mem_word(32'h100));
    end
    fetch_en = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    fetch_en = 1'b1; id_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h2A;
    tick();
    checks++;
    if (fault !== 1'b1 || fault_pc !== 32'h2A || id_valid !== 1'b0 || imem_addr !== 32'h108 || dbg_state !== ST_FAULT) begin
      errors++;
      $display("FAIL misalign_enter: f=%b fpc=%h v=%b addr=%h st=%0d, expected f=1 fpc=2a v=0 addr=108 st=2",
               fault, fault_pc, id_valid, imem_addr, dbg_state);
    end
    for (int i = 0; i < 10; i++) begin
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_pc = {$urandom_range(0, 1023) << 2} | 32'($urandom_range(0, 3));
      id_ready = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (fault !== 1'b1 || fault_pc !== 32'h2A || id_valid !== 1'b0 || imem_addr !== 32'h108) begin
        errors++;
        $display("FAIL misalign_sticky_%0d: f=%b fpc=%h v=%b addr=%h, expected f=1 fpc=2a v=0 addr=108",
                 i, fault, fault_pc, id_valid, imem_addr);
      end
    end
    redirect_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (fault !== 1'b0 || fault_pc !== 32'h0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL misalign_reset: f=%b fpc=%h st=%0d, expected f=0 fpc=0 st=0", fault, fault_pc, dbg_state);
    end
    fetch_en = 1'b0;
    #1 reset = 1'b0;
  endtask

  task automatic test_wrap();
    reset2 = 1'b0; fetch_en2 = 1'b1;
    tick();
    checks++;
    if (imem_addr2 !== 32'hFFFF_FFFC || id_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_start: addr=%h v=%b, expected addr=fffffffc v=0", imem_addr2, id_valid2);
    end
    tick();
    checks++;
    if (id_valid2 !== 1'b1 || id_pc2 !== 32'hFFFF_FFFC || id_pc_plus42 !== 32'h0 ||
        id_instr2 !== mem_word(32'hFFFF_FFFC) || imem_addr2 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_top: v=%b pc=%h pc4=%h instr=%h addr=%h, expected pc=fffffffc pc4=0 addr=0",
               id_valid2, id_pc2, id_pc_plus42, id_instr2, imem_addr2);
    end
    tick();
    checks++;
    if (id_valid2 !== 1'b1 || id_pc2 !== 32'h0 || id_pc_plus42 !== 32'h4 || id_instr2 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_zero: v=%b pc=%h pc4=%h instr=%h, expected pc=0 pc4=4 instr=0",
               id_valid2, id_pc2, id_pc_plus42, id_instr2);
    end
    fetch_en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_async_reset();
    test_idle_redirect();
    test_misaligned();
    test_wrap();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected transfers never seen, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
